// File: rtl/mprj_io_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// mprj_io_cfg_sequencer
//
// Sequences the per-pad configuration of the user GPIO pad ring. On start,
// one configuration word per pad is fetched from a register file. The words
// are shifted MSB first onto two serial chains in parallel: chain 1 carries
// pads 0..AREA1PADS-1 and chain 2 carries the remaining pads. A final load
// strobe makes the pad control blocks latch the new settings.
//
// Ports:
//   clock          system clock, all logic on the rising edge
//   resetn         asynchronous active-low reset
//   start          request a full reconfiguration (sampled only in IDLE)
//   abort          cancel an in-progress sequence
//   busy           high from the cycle after start through the last LOAD cycle
//   done           one-cycle pulse on successful completion
//   cfg_rd         register-file read strobe
//   cfg_addr       pad index being read (held while cfg_rd is low)
//   cfg_rdata      read data, valid the cycle after cfg_rd
//   serial_clock   chain shift clock
//   serial_load    chain latch strobe
//   serial_data_1  chain 1 serial data
//   serial_data_2  chain 2 serial data
// ---------------------------------------------------------------------------
module mprj_io_cfg_sequencer #(
    parameter int TOTAL_PADS = 38,
    parameter int AREA1PADS  = 19,
    parameter int CFG_BITS   = 13,
    parameter int DIV        = 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                cfg_rd,
    output logic [5:0]          cfg_addr,
    input  logic [CFG_BITS-1:0] cfg_rdata,
    output logic                serial_clock,
    output logic                serial_load,
    output logic                serial_data_1,
    output logic                serial_data_2
);

    localparam int N1 = AREA1PADS;
    localparam int N2 = TOTAL_PADS - AREA1PADS;
    localparam int S  = (N1 > N2) ? N1 : N2;
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int PW = $clog2(2 * DIV);

    localparam logic [5:0]    SLOT_LAST = 6'(S - 1);
    localparam logic [5:0]    SKIP2     = 6'(S - N2);
    localparam logic [5:0]    A1        = 6'(AREA1PADS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] PH_HIGH   = PW'(DIV);

    typedef enum logic [2:0] {
        IDLE,
        FETCH1,
        FETCH2,
        LATCH,
        SHIFT,
        LOAD
    } state_t;

    state_t               state;
    logic [5:0]           slot;
    logic [BW-1:0]        bit_cnt;
    logic [PW-1:0]        ph;
    logic [CFG_BITS-1:0]  sh1;
    logic [CFG_BITS-1:0]  sh2;

    // The shorter chain is padded at the front with dummy slots so that both
    // chains finish together and the farthest pad is always shifted first.
    function automatic logic is_dummy1(input logic [5:0] k);
        return int'(k) < (S - N1);
    endfunction

    function automatic logic is_dummy2(input logic [5:0] k);
        return int'(k) < (S - N2);
    endfunction

    function automatic logic [5:0] pad1(input logic [5:0] k);
        return SLOT_LAST - k;
    endfunction

    function automatic logic [5:0] pad2(input logic [5:0] k);
        return A1 + k - SKIP2;
    endfunction

    logic [5:0]          slot_inc;
    logic [5:0]          fetch_slot;
    logic                fetch_rd;
    logic [5:0]          fetch_addr;
    logic [PW-1:0]       ph_inc;
    logic [CFG_BITS-1:0] rdata1;
    logic [CFG_BITS-1:0] rdata2;

    always_comb begin
        slot_inc   = slot + 6'd1;
        // FETCH1 is entered from IDLE (slot 0) or from SHIFT (next slot).
        fetch_slot = (state == IDLE) ? 6'd0 : slot_inc;
        fetch_rd   = !is_dummy1(fetch_slot);
        fetch_addr = pad1(fetch_slot);
        ph_inc     = ph + 1'b1;
        rdata1     = is_dummy1(slot) ? '0 : cfg_rdata;
        rdata2     = is_dummy2(slot) ? '0 : cfg_rdata;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            slot          <= '0;
            bit_cnt       <= '0;
            ph            <= '0;
            sh1           <= '0;
            sh2           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_rd        <= 1'b0;
            cfg_addr      <= '0;
            serial_clock  <= 1'b0;
            serial_load   <= 1'b0;
            serial_data_1 <= 1'b0;
            serial_data_2 <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                // Abort drops the chains quietly: no load strobe, no done.
                state         <= IDLE;
                busy          <= 1'b0;
                cfg_rd        <= 1'b0;
                serial_clock  <= 1'b0;
                serial_load   <= 1'b0;
                serial_data_1 <= 1'b0;
                serial_data_2 <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state  <= FETCH1;
                            busy   <= 1'b1;
                            slot   <= '0;
                            cfg_rd <= fetch_rd;
                            if (fetch_rd) cfg_addr <= fetch_addr;
                        end
                    end
                    FETCH1: begin
                        state  <= FETCH2;
                        cfg_rd <= !is_dummy2(slot);
                        if (!is_dummy2(slot)) cfg_addr <= pad2(slot);
                    end
                    FETCH2: begin
                        state  <= LATCH;
                        cfg_rd <= 1'b0;
                        sh1    <= rdata1;
                    end
                    LATCH: begin
                        // The first bit goes out together with the chain 2
                        // capture; the registers keep the remaining bits.
                        state         <= SHIFT;
                        serial_data_1 <= sh1[CFG_BITS-1];
                        serial_data_2 <= rdata2[CFG_BITS-1];
                        sh1           <= sh1 << 1;
                        sh2           <= rdata2 << 1;
                        bit_cnt       <= '0;
                        ph            <= '0;
                        serial_clock  <= 1'b0;
                    end
                    SHIFT: begin
                        if (ph == PH_LAST) begin
                            ph           <= '0;
                            serial_clock <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                if (slot == SLOT_LAST) begin
                                    state       <= LOAD;
                                    serial_load <= 1'b1;
                                end else begin
                                    state  <= FETCH1;
                                    slot   <= slot_inc;
                                    cfg_rd <= fetch_rd;
                                    if (fetch_rd) cfg_addr <= fetch_addr;
                                end
                            end else begin
                                bit_cnt       <= bit_cnt + 1'b1;
                                serial_data_1 <= sh1[CFG_BITS-1];
                                serial_data_2 <= sh2[CFG_BITS-1];
                                sh1           <= sh1 << 1;
                                sh2           <= sh2 << 1;
                            end
                        end else begin
                            ph           <= ph_inc;
                            serial_clock <= (ph_inc >= PH_HIGH);
                        end
                    end
                    LOAD: begin
                        if (ph == PH_LAST) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            serial_load <= 1'b0;
                            ph          <= '0;
                        end else begin
                            ph          <= ph_inc;
                            serial_load <= (ph_inc < PH_HIGH);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mprj_io_cfg_sequencer.sv
module tb_mprj_io_cfg_sequencer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic clr = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [2:0] start = '0;
    logic [2:0] abort = '0;
    logic [2:0] busy, done, rd, sc, sl, sd1, sd2;
    logic [5:0]  addr  [3];
    logic [12:0] rdata [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: data for the addressed pad one cycle after cfg_rd.
    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            if (rd[i]) rdata[i] <= 13'h1000 | {7'd0, addr[i]};

    mprj_io_cfg_sequencer dut0 (
        .clock(clk), .resetn(resetn), .start(start[0]), .abort(abort[0]),
        .busy(busy[0]), .done(done[0]), .cfg_rd(rd[0]), .cfg_addr(addr[0]),
        .cfg_rdata(rdata[0]), .serial_clock(sc[0]), .serial_load(sl[0]),
        .serial_data_1(sd1[0]), .serial_data_2(sd2[0]));

    mprj_io_cfg_sequencer #(.TOTAL_PADS(38), .AREA1PADS(16)) dut1 (
        .clock(clk), .resetn(resetn), .start(start[1]), .abort(abort[1]),
        .busy(busy[1]), .done(done[1]), .cfg_rd(rd[1]), .cfg_addr(addr[1]),
        .cfg_rdata(rdata[1]), .serial_clock(sc[1]), .serial_load(sl[1]),
        .serial_data_1(sd1[1]), .serial_data_2(sd2[1]));

    mprj_io_cfg_sequencer #(.DIV(3)) dut2 (
        .clock(clk), .resetn(resetn), .start(start[2]), .abort(abort[2]),
        .busy(busy[2]), .done(done[2]), .cfg_rd(rd[2]), .cfg_addr(addr[2]),
        .cfg_rdata(rdata[2]), .serial_clock(sc[2]), .serial_load(sl[2]),
        .serial_data_1(sd1[2]), .serial_data_2(sd2[2]));

    // Per-DUT observation of the serial chains and read port.
    int          edges [3], nrd [3], nw [3], bits [3], hi_run [3];
    int          ldcyc [3], ndone [3], nbusy [3], viol [3];
    logic [12:0] w1 [3], w2 [3];
    logic [12:0] w1_log [3][32];
    logic [12:0] w2_log [3][32];
    logic [5:0]  rd_log [3][64];
    logic        sc_prev [3], sd1_prev [3], sd2_prev [3];
    logic [5:0]  addr_prev [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                edges[i] = 0; nrd[i] = 0; nw[i] = 0; bits[i] = 0;
                hi_run[i] = 0; ldcyc[i] = 0; ndone[i] = 0; nbusy[i] = 0;
                viol[i] = 0; w1[i] = '0; w2[i] = '0;
            end else begin
                if (rd[i]) begin
                    if (nrd[i] < 64) rd_log[i][nrd[i]] = addr[i];
                    nrd[i]++;
                end else if (addr[i] !== addr_prev[i]) viol[i]++;
                if (sc[i] && !sc_prev[i]) begin
                    edges[i]++;
                    w1[i] = {w1[i][11:0], sd1[i]};
                    w2[i] = {w2[i][11:0], sd2[i]};
                    bits[i]++;
                    if (bits[i] == 13) begin
                        bits[i] = 0;
                        if (nw[i] < 32) begin
                            w1_log[i][nw[i]] = w1[i];
                            w2_log[i][nw[i]] = w2[i];
                        end
                        nw[i]++;
                    end
                end
                if (sc[i]) begin
                    hi_run[i]++;
                    if (sd1[i] !== sd1_prev[i] || sd2[i] !== sd2_prev[i]) viol[i]++;
                end else begin
                    if (sc_prev[i] && hi_run[i] != ((i == 2) ? 3 : 1)) viol[i]++;
                    hi_run[i] = 0;
                end
                if (sl[i]) ldcyc[i]++;
                if (done[i]) ndone[i]++;
                if (busy[i]) nbusy[i]++;
            end
            sc_prev[i] = sc[i]; sd1_prev[i] = sd1[i]; sd2_prev[i] = sd2[i];
            addr_prev[i] = addr[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic wait_done(input int i, input int max_cyc, input string tag);
        int n = 0;
        while (!done[i] && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_done_seen"}, done[i], 1'b1);
    endtask

    // Start DUT i, wait for done and check the start-to-done latency.
    task automatic run_seq(input int i, input int exp_lat, input string tag);
        int c0;
        c0 = cyc;
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        check({tag, "_busy_rise"}, busy[i], 1'b1);
        wait_done(i, exp_lat + 50, tag);
        check({tag, "_latency"}, cyc - c0, exp_lat);
        check({tag, "_busy_low_at_done"}, busy[i], 1'b0);
    endtask

    function automatic logic [12:0] outs(input int i);
        return {busy[i], done[i], rd[i], sc[i], sl[i], sd1[i], sd2[i], addr[i]};
    endfunction

    initial begin
        // Reset held with start asserted.
        resetn = 1'b0;
        start  = 3'b111;
        clr    = 1'b1;
        repeat (3) step();
        check("reset_outs_d0", outs(0), 13'h0);
        check("reset_outs_d1", outs(1), 13'h0);
        check("reset_outs_d2", outs(2), 13'h0);
        resetn = 1'b1;
        start  = 3'b000;
        clr    = 1'b0;
        repeat (20) step();
        check("idle_after_reset", {busy, done, rd}, 9'h0);
        check("idle_no_busy_cycles", nbusy[0], 0);

        // Nominal run, default parameters.
        clear();
        run_seq(0, 554, "nom");
        step();
        check("nom_reads", nrd[0], 38);
        for (int k = 0; k < 19; k++) begin
            check($sformatf("nom_rd_c1_%0d", k), rd_log[0][2*k], 18 - k);
            check($sformatf("nom_rd_c2_%0d", k), rd_log[0][2*k+1], 19 + k);
        end
        check("nom_words", nw[0], 19);
        for (int k = 0; k < 19; k++) begin
            check($sformatf("nom_w1_%0d", k), w1_log[0][k], 13'h1000 | (18 - k));
            check($sformatf("nom_w2_%0d", k), w2_log[0][k], 13'h1000 | (19 + k));
        end
        check("nom_edges", edges[0], 247);
        check("nom_load_cycles", ldcyc[0], 1);
        check("nom_busy_cycles", nbusy[0], 553);
        check("nom_done_count", ndone[0], 1);
        check("nom_viol", viol[0], 0);

        // Unequal chains: AREA1PADS=16.
        clear();
        run_seq(1, 641, "uneq");
        step();
        check("uneq_reads", nrd[1], 38);
        check("uneq_first_rd", rd_log[1][0], 16);
        check("uneq_second_rd", rd_log[1][1], 17);
        check("uneq_seventh_rd", rd_log[1][6], 15);
        check("uneq_edges", edges[1], 286);
        for (int k = 0; k < 6; k++)
            check($sformatf("uneq_dummy_w1_%0d", k), w1_log[1][k], 13'h0);
        check("uneq_w1_6", w1_log[1][6], 13'h100F);
        check("uneq_w1_21", w1_log[1][21], 13'h1000);
        check("uneq_w2_0", w2_log[1][0], 13'h1010);
        check("uneq_w2_21", w2_log[1][21], 13'h1025);
        check("uneq_viol", viol[1], 0);

        // Slow serial clock: DIV=3.
        clear();
        run_seq(2, 1546, "div3");
        step();
        check("div3_busy_cycles", nbusy[2], 1545);
        check("div3_edges", edges[2], 247);
        check("div3_load_cycles", ldcyc[2], 3);
        check("div3_w1_0", w1_log[2][0], 13'h1012);
        check("div3_w2_18", w2_log[2][18], 13'h1025);
        check("div3_viol", viol[2], 0);

        // Abort in the middle of slot 5's shift.
        clear();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        begin
            int n = 0;
            while (edges[0] < 70 && n < 2000) begin
                step();
                n++;
            end
        end
        check("abort_reached_slot5", edges[0], 70);
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        check("abort_outs", {busy[0], done[0], rd[0], sc[0], sl[0], sd1[0], sd2[0]}, 7'h0);
        repeat (600) step();
        check("abort_no_load", ldcyc[0], 0);
        check("abort_no_done", ndone[0], 0);
        check("abort_stays_idle", busy[0], 1'b0);
        clear();
        run_seq(0, 554, "rerun");
        check("rerun_rd0", rd_log[0][0], 18);
        check("rerun_rd1", rd_log[0][1], 19);
        check("rerun_reads", nrd[0], 38);

        // start and abort together in IDLE: abort wins.
        start[0] = 1'b1;
        abort[0] = 1'b1;
        step();
        start[0] = 1'b0;
        abort[0] = 1'b0;
        check("start_abort_idle_busy", busy[0], 1'b0);
        check("start_abort_idle_rd", rd[0], 1'b0);
        repeat (3) step();
        check("start_abort_idle_later", busy[0], 1'b0);

        // start held every cycle: ignored while busy, accepted with done.
        begin
            int c0;
            c0 = cyc;
            start[0] = 1'b1;
            step();
            wait_done(0, 600, "b2b");
            check("b2b_latency", cyc - c0, 554);
            check("b2b_gap_busy_low", busy[0], 1'b0);
            step();
            check("b2b_restart_busy", busy[0], 1'b1);
            check("b2b_restart_done_low", done[0], 1'b0);
            start[0] = 1'b0;
            abort[0] = 1'b1;
            step();
            abort[0] = 1'b0;
            check("b2b_abort_busy", busy[0], 1'b0);
        end

        // Asynchronous reset in the middle of a sequence.
        clear();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        repeat (100) step();
        resetn = 1'b0;
        #1;
        check("midreset_outs", outs(0), 13'h0);
        step();
        resetn = 1'b1;
        repeat (5) step();
        check("midreset_idle", busy[0], 1'b0);
        check("midreset_no_done", ndone[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mprj_io_cfg_sequencer.md
Name: mprj_io_cfg_sequencer

Overview:
Sequences the per-pad configuration of the user-project GPIO pad ring.
- On a start request, reads one CFG_BITS-wide configuration word per pad from a configuration register file.
- Shifts the words out over two serial chains: area 1 (pads 0..AREA1PADS-1) and area 2 (pads AREA1PADS..TOTAL_PADS-1). Both chains shift in parallel.
- Pulses a load strobe at the end so the pad control blocks latch the new settings (oeb, inp_dis, dm, etc.).

Parameters:
- TOTAL_PADS, 38, total user GPIO pads.
- AREA1PADS, 19, pads on chain 1; chain 2 holds TOTAL_PADS-AREA1PADS. Range 1..TOTAL_PADS-1.
- CFG_BITS, 13, configuration bits per pad.
- DIV, 1, serial clock half-period in clock cycles (>=1).

Ports:
- clock, input, 1, system clock; all logic rising-edge.
- resetn, input, 1, reset, asynchronous, active-low.
- start, input, 1, request a full reconfiguration; sampled only in IDLE.
- abort, input, 1, cancel an in-progress sequence.
- busy, output, 1, high from the cycle after start is accepted through the last LOAD cycle.
- done, output, 1, one-cycle pulse on successful completion.
- cfg_rd, output, 1, register-file read strobe.
- cfg_addr, output, 6, pad index being read.
- cfg_rdata, input, CFG_BITS, read data; valid the cycle after cfg_rd.
- serial_clock, output, 1, chain shift clock.
- serial_load, output, 1, chain latch strobe.
- serial_data_1, output, 1, chain 1 data.
- serial_data_2, output, 1, chain 2 data.

Behaviour:
- Reset values: all outputs 0. State IDLE; counters and shift registers cleared.
- Outputs: all registered; no combinational path from any input to any output.
- Slot count: S = max(AREA1PADS, TOTAL_PADS-AREA1PADS), slots k = 0..S-1.
- Slot-to-pad mapping (farthest pad shifted first):
  - Chain 1 pad = AREA1PADS-1-(k-(S-N1)), where N1 = AREA1PADS.
  - Chain 2 pad = AREA1PADS+(k-(S-N2)), where N2 = TOTAL_PADS-AREA1PADS.
  - Slots with k < S-Nx are dummy slots for that chain: no read is issued and the shift word is all zeros.
- FSM states: IDLE -> FETCH1 -> FETCH2 -> LATCH -> SHIFT -> (next slot FETCH1 | LOAD) -> IDLE.
- IDLE: start=1 moves to FETCH1 with k=0. busy rises the next cycle.
- FETCH1: cfg_rd=1, cfg_addr = chain 1 pad. cfg_rd=0 if this is a chain 1 dummy slot.
- FETCH2: cfg_rd=1, cfg_addr = chain 2 pad (or cfg_rd=0 if chain 2 dummy). Captures cfg_rdata (or zero) into sh1.
- LATCH: captures cfg_rdata (or zero) into sh2. cfg_rd=0.
- SHIFT:
  - CFG_BITS bits, MSB first, each bit 2*DIV cycles.
  - serial_clock=0 for DIV cycles, then 1 for DIV cycles.
  - serial_data_x changes only on the cycle serial_clock returns low, i.e. at the first cycle of each bit.
  - After the last bit: serial_clock=0. Go to FETCH1 with k+1, or to LOAD if k=S-1.
- LOAD: serial_load=1 for DIV cycles, then 0 for DIV cycles. Then go to IDLE, done=1 for one cycle, busy=0.
- Latency with defaults: busy high for S*(3+2*DIV*CFG_BITS)+2*DIV = 553 cycles. done fires in the cycle after the last busy cycle.
- Boundary conditions:
  - start while busy: ignored.
  - start on the same cycle done pulses: accepted. A new sequence begins and busy stays low for exactly one cycle.
  - abort=1 in any non-IDLE state: next cycle IDLE. serial_clock, serial_load and serial_data_x go to 0, and no done pulse. serial_load is never asserted if the abort occurs before LOAD. abort beats start in the same cycle.
  - resetn low mid-operation: immediate return to the reset values.
  - cfg_addr is held at its last value when cfg_rd=0.

Test Plan:
- Reset: hold resetn=0 with start=1 -> all outputs 0. Release, start=0 -> IDLE, busy=0 indefinitely.
- Nominal, defaults, cfg_rdata = 13'h1000|pad index:
  - Read order is 18,19,17,20,...,0,37.
  - Chain 1 decoded word sequence is pad 18 down to 0; chain 2 is 19 up to 37.
  - 247 serial_clock rising edges per chain.
  - serial_load is one cycle high; done at cycle 554 after start.
- Unequal chains, AREA1PADS=16, TOTAL_PADS=38:
  - S=22; chain 1 shifts 6 zero words first with no cfg_rd for them.
  - Total cfg_rd pulses = 38.
- DIV=3:
  - Each serial_clock phase lasts 3 cycles; data stable across every rising edge.
  - busy length = 19*(3+78)+6 = 1545.
- Abort at slot 5 mid-SHIFT:
  - Outputs 0 next cycle; no serial_load, no done.
  - A subsequent start reruns from slot 0 with read order starting 18,19.
- Start/abort/busy interactions:
  - start pulsed every cycle -> back-to-back sequences with a single-cycle busy gap.
  - start and abort together in IDLE -> stays IDLE.
